tt_vfp_red_seq: RTL and testbench
=================================

// Module: tt_vfp_red_seq
// PURPOSE
//  Upstream sequencer for tt_vfp_red: accepts one FP reduction request (vector of recoded elements, mask, vl,
//  op, rounding mode, scalar init), drives the reduction unit one element per cycle, OR-accumulates exception
//  flags across all beats, and returns the final standard-format result on a valid/ready handshake.
// PARAMETERS
//  EXP_W     5   exponent width (matches tt_vfp_red expWidth)
//  SIG_W     11  significand width (matches tt_vfp_red sigWidth)
//  NUM_ELEM  8   max elements per request; VL_W = $clog2(NUM_ELEM+1); REC_W = EXP_W+SIG_W+1; FN_W = EXP_W+SIG_W
// PORTS
//  i_clk          in   1               clock
//  i_reset        in   1               asynchronous, active-high reset
//  i_req_valid    in   1               request valid
//  o_req_ready    out  1               request ready (high only in IDLE)
//  i_req_op       in   2               0 sum, 2 min, 3 max (1 reserved, treated as sum)
//  i_req_rm       in   3               rounding mode
//  i_req_vl       in   VL_W            active element count; values > NUM_ELEM clamp to NUM_ELEM
//  i_req_mask     in   NUM_ELEM        per-element enable, bit k = element k
//  i_req_scalar   in   REC_W           recoded scalar initial value
//  i_req_vec      in   NUM_ELEM*REC_W  recoded elements, element k at [k*REC_W +: REC_W]
//  o_red_valid    out  1               -> tt_vfp_red i_valid
//  o_red_en       out  1               -> i_en
//  o_red_sel      out  1               -> i_sel (0 on first beat only)
//  o_red_op       out  2               -> i_op
//  o_red_rm       out  3               -> i_roundingMode
//  o_red_a        out  REC_W           -> i_a (latched scalar)
//  o_red_c        out  REC_W           -> i_c (current element)
//  i_red_res      in   FN_W            <- o_res
//  i_red_exc      in   5               <- o_exc
//  o_res_valid    out  1               result valid
//  i_res_ready    in   1               result ready
//  o_res          out  FN_W            final result (standard format)
//  o_exc          out  5               OR of all beat exception flags
// BEHAVIOUR
//  - Reset (any time, incl. mid-operation): FSM->IDLE; all outputs 0 except o_req_ready=1; latched request,
//    element index, exc accumulator cleared. Aborted request is lost, no result emitted.
//  - FSM IDLE->ISSUE on i_req_valid&&o_req_ready (request fields registered). ISSUE->DRAIN after last beat.
//    DRAIN->DONE unconditionally. DONE->IDLE on i_res_ready.
//  - Beats: one per ISSUE cycle, o_red_valid=1; beat j has o_red_c=element idx, o_red_en=mask[idx],
//    o_red_sel=(j!=0). vl=0 issues exactly one beat with o_red_en=0,o_red_sel=0 (red unit latches scalar).
//  - Exc: acc_exc |= i_red_exc in every cycle following a beat (ISSUE cycles j>=1 and DRAIN); cleared on accept.
//  - DRAIN: capture i_red_res into o_res and final acc_exc into o_exc; DONE: o_res_valid=1, outputs stable
//    until handshake. No new request accepted before DONE completes (no overlap).
//  - Latency accept->o_res_valid = beats+2 cycles (vl=4 without skip: beats c1-c4, DRAIN c5, valid c6).
//  - o_red_op/o_red_rm/o_red_a held from registered request for whole ISSUE phase; zero in IDLE.
// CONFIGURATION
//  TT_VFP_RED_SEQ_SKIP_EN defined: after the first beat, elements with mask=0 are skipped (find-next-set over
//   mask[vl-1:0]); beats = 1 + popcount(mask[vl-1:1]) ... first beat always at element 0.
//  Undefined: one beat per element 0..vl-1 (masked beats issued with o_red_en=0). Results identical; only latency differs.
// STRUCTURE
//  Package tt_vfp_red_pkg: typedef red_op_e {RED_SUM=0,RED_RSVD=1,RED_MIN=2,RED_MAX=3}, typedef seq_state_e
//  {IDLE,ISSUE,DRAIN,DONE}, localparams for REC_W/FN_W helpers. Optional sub-module tt_vfp_red_seq_nxt
//  (find-next-set-bit above index, used only with SKIP_EN).
// TESTING (EXP_W=5, SIG_W=11, NUM_ELEM=8, tt_vfp_red instantiated downstream)
//  1 sum, scalar 0.5, elems 1.0,2.0,3.0, vl=3, mask=0xFF -> o_res=0x4680 (6.5), o_exc=0, valid 5 cycles after accept.
//  2 vl=0, scalar 0x3C00 (1.0), any op -> one beat en=0 sel=0; o_res=0x3C00, o_exc=0, valid 3 cycles after accept.
//  3 max, scalar -1.0, elems 4.0,9.0,2.0,7.0, vl=4, mask=0b1101 -> o_res=0x4700 (7.0); SKIP_EN: 3 beats, else 4.
//  4 min, vl=3, elem1 = sNaN, others 1.0 -> o_exc=0x10 (NV sticky though last beat clean), o_res=0x3C00.
//  5 i_res_ready low 10 cycles in DONE -> o_res/o_exc stable, o_req_ready=0, new i_req_valid ignored.
//  6 assert i_reset during ISSUE beat 2 -> next cycle all outputs 0, o_req_ready=1; next request result correct.

Source files
------------

// File: rtl/tt_vfp_red_pkg.sv
// Shared types, default sizes and width helpers for the tt_vfp_red request sequencer.
package tt_vfp_red_pkg;

    typedef enum logic [1:0] {
        RED_SUM  = 2'd0,
        RED_RSVD = 2'd1,
        RED_MIN  = 2'd2,
        RED_MAX  = 2'd3
    } red_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int EXC_W        = 5;
    localparam int DEF_EXP_W    = 5;
    localparam int DEF_SIG_W    = 11;
    localparam int DEF_NUM_ELEM = 8;

    // Recoded format carries one extra exponent bit over the standard format.
    function automatic int rec_width(input int exp_w, input int sig_w);
        return exp_w + sig_w + 1;
    endfunction

    function automatic int fn_width(input int exp_w, input int sig_w);
        return exp_w + sig_w;
    endfunction

    // The reserved opcode is issued downstream as a plain sum.
    function automatic red_op_e map_op(input logic [1:0] op);
        return (op == RED_RSVD) ? RED_SUM : red_op_e'(op);
    endfunction

endpackage

// File: rtl/tt_vfp_red_seq_nxt.sv
// Find-next-set-bit above a given element index, limited to the active vector length.
// Used by tt_vfp_red_seq only when TT_VFP_RED_SEQ_SKIP_EN is defined.
module tt_vfp_red_seq_nxt
    import tt_vfp_red_pkg::*;
#(
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    localparam int VL_W = $clog2(NUM_ELEM + 1)
) (
    input  logic [NUM_ELEM-1:0] mask,
    input  logic [VL_W-1:0]     vl,
    input  logic [VL_W-1:0]     idx,
    output logic                found,
    output logic [VL_W-1:0]     nxt
);

    // Scan downwards so the lowest qualifying element wins.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int k = NUM_ELEM - 1; k >= 0; k--) begin
            if ((VL_W'(k) > idx) && (VL_W'(k) < vl) && mask[k]) begin
                found = 1'b1;
                nxt   = VL_W'(k);
            end
        end
    end

endmodule

// File: rtl/tt_vfp_red_seq.sv
// Request sequencer feeding tt_vfp_red one element per cycle and returning the final result.
// Optional TT_VFP_RED_SEQ_SKIP_EN: masked-off elements after the first beat are not issued.
module tt_vfp_red_seq
    import tt_vfp_red_pkg::*;
#(
    parameter int EXP_W    = DEF_EXP_W,
    parameter int SIG_W    = DEF_SIG_W,
    parameter int NUM_ELEM = DEF_NUM_ELEM,
    localparam int VL_W    = $clog2(NUM_ELEM + 1),
    localparam int REC_W   = rec_width(EXP_W, SIG_W),
    localparam int FN_W    = fn_width(EXP_W, SIG_W)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [1:0]                i_req_op,
    input  logic [2:0]                i_req_rm,
    input  logic [VL_W-1:0]           i_req_vl,
    input  logic [NUM_ELEM-1:0]       i_req_mask,
    input  logic [REC_W-1:0]          i_req_scalar,
    input  logic [NUM_ELEM*REC_W-1:0] i_req_vec,
    output logic                      o_red_valid,
    output logic                      o_red_en,
    output logic                      o_red_sel,
    output logic [1:0]                o_red_op,
    output logic [2:0]                o_red_rm,
    output logic [REC_W-1:0]          o_red_a,
    output logic [REC_W-1:0]          o_red_c,
    input  logic [FN_W-1:0]           i_red_res,
    input  logic [EXC_W-1:0]          i_red_exc,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [FN_W-1:0]           o_res,
    output logic [EXC_W-1:0]          o_exc
);

    seq_state_e                state;
    logic [NUM_ELEM*REC_W-1:0] vec_q;
    logic [NUM_ELEM-1:0]       mask_q;
    logic [VL_W-1:0]           vl_q;
    logic [VL_W-1:0]           idx;
    logic [EXC_W-1:0]          acc_exc;

    logic [VL_W-1:0]           vl_in;
    logic [VL_W-1:0]           nxt_idx;
    logic                      nxt_ok;
    logic [REC_W-1:0]          nxt_elem;
    logic                      nxt_en;

    assign vl_in = (i_req_vl > VL_W'(NUM_ELEM)) ? VL_W'(NUM_ELEM) : i_req_vl;

`ifdef TT_VFP_RED_SEQ_SKIP_EN
    tt_vfp_red_seq_nxt #(
        .NUM_ELEM (NUM_ELEM)
    ) u_nxt (
        .mask  (mask_q),
        .vl    (vl_q),
        .idx   (idx),
        .found (nxt_ok),
        .nxt   (nxt_idx)
    );
`else
    always_comb begin
        nxt_idx = idx + VL_W'(1);
        nxt_ok  = (nxt_idx < vl_q);
    end
`endif

    always_comb begin
        nxt_elem = '0;
        nxt_en   = 1'b0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (nxt_idx == VL_W'(k)) begin
                nxt_elem = vec_q[k*REC_W +: REC_W];
                nxt_en   = mask_q[k];
            end
        end
    end

    // Beat outputs are registered one cycle ahead, so the first beat is loaded on accept.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            vec_q       <= '0;
            mask_q      <= '0;
            vl_q        <= '0;
            idx         <= '0;
            acc_exc     <= '0;
            o_req_ready <= 1'b1;
            o_red_valid <= 1'b0;
            o_red_en    <= 1'b0;
            o_red_sel   <= 1'b0;
            o_red_op    <= '0;
            o_red_rm    <= '0;
            o_red_a     <= '0;
            o_red_c     <= '0;
            o_res_valid <= 1'b0;
            o_res       <= '0;
            o_exc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        state       <= ISSUE;
                        vec_q       <= i_req_vec;
                        mask_q      <= i_req_mask;
                        vl_q        <= vl_in;
                        idx         <= '0;
                        acc_exc     <= '0;
                        o_req_ready <= 1'b0;
                        o_red_valid <= 1'b1;
                        o_red_en    <= (vl_in != '0) && i_req_mask[0];
                        o_red_sel   <= 1'b0;
                        o_red_op    <= map_op(i_req_op);
                        o_red_rm    <= i_req_rm;
                        o_red_a     <= i_req_scalar;
                        o_red_c     <= i_req_vec[0 +: REC_W];
                    end
                end

                ISSUE: begin
                    // Flags seen during a sel=1 beat belong to the previous beat.
                    if (o_red_sel) begin
                        acc_exc <= acc_exc | i_red_exc;
                    end
                    if (nxt_ok) begin
                        idx       <= nxt_idx;
                        o_red_c   <= nxt_elem;
                        o_red_en  <= nxt_en;
                        o_red_sel <= 1'b1;
                    end else begin
                        state       <= DRAIN;
                        idx         <= '0;
                        o_red_valid <= 1'b0;
                        o_red_en    <= 1'b0;
                        o_red_sel   <= 1'b0;
                        o_red_op    <= '0;
                        o_red_rm    <= '0;
                        o_red_a     <= '0;
                        o_red_c     <= '0;
                    end
                end

                DRAIN: begin
                    state       <= DONE;
                    acc_exc     <= acc_exc | i_red_exc;
                    o_res       <= i_red_res;
                    o_exc       <= acc_exc | i_red_exc;
                    o_res_valid <= 1'b1;
                end

                DONE: begin
                    if (i_res_ready) begin
                        state       <= IDLE;
                        o_res_valid <= 1'b0;
                        o_res       <= '0;
                        o_exc       <= '0;
                        o_req_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_vfp_red_seq.sv
// Self-checking bench for tt_vfp_red_seq; the downstream reduction unit is a stub driving random results.
// Honours TT_VFP_RED_SEQ_SKIP_EN when building the expected beat list.
module tb_tt_vfp_red_seq;

    localparam int NUM_ELEM = 8;
    localparam int REC_W    = 17;
    localparam int FN_W     = 16;
    localparam int VL_W     = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [2:0]                req_rm;
    logic [VL_W-1:0]           req_vl;
    logic [NUM_ELEM-1:0]       req_mask;
    logic [REC_W-1:0]          req_scalar;
    logic [NUM_ELEM*REC_W-1:0] req_vec;
    logic                      red_valid;
    logic                      red_en;
    logic                      red_sel;
    logic [1:0]                red_op;
    logic [2:0]                red_rm;
    logic [REC_W-1:0]          red_a;
    logic [REC_W-1:0]          red_c;
    logic [FN_W-1:0]           red_res;
    logic [4:0]                red_exc;
    logic                      res_valid;
    logic                      res_ready;
    logic [FN_W-1:0]           res;
    logic [4:0]                exc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tt_vfp_red_seq #(
        .EXP_W    (5),
        .SIG_W    (11),
        .NUM_ELEM (NUM_ELEM)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_rm     (req_rm),
        .i_req_vl     (req_vl),
        .i_req_mask   (req_mask),
        .i_req_scalar (req_scalar),
        .i_req_vec    (req_vec),
        .o_red_valid  (red_valid),
        .o_red_en     (red_en),
        .o_red_sel    (red_sel),
        .o_red_op     (red_op),
        .o_red_rm     (red_rm),
        .o_red_a      (red_a),
        .o_red_c      (red_c),
        .i_red_res    (red_res),
        .i_red_exc    (red_exc),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res        (res),
        .o_exc        (exc)
    );

    function automatic logic [NUM_ELEM*REC_W-1:0] rand_vec();
        logic [NUM_ELEM*REC_W-1:0] v;
        for (int k = 0; k < NUM_ELEM; k++) v[k*REC_W +: REC_W] = REC_W'($urandom);
        return v;
    endfunction

    function automatic logic [NUM_ELEM*REC_W-1:0] pack4(input logic [REC_W-1:0] e0, input logic [REC_W-1:0] e1,
                                                        input logic [REC_W-1:0] e2, input logic [REC_W-1:0] e3);
        logic [NUM_ELEM*REC_W-1:0] v;
        v = rand_vec();
        v[0*REC_W +: REC_W] = e0;
        v[1*REC_W +: REC_W] = e1;
        v[2*REC_W +: REC_W] = e2;
        v[3*REC_W +: REC_W] = e3;
        return v;
    endfunction

    task automatic scramble_req();
        req_op     = 2'($urandom);
        req_rm     = 3'($urandom);
        req_vl     = VL_W'($urandom);
        req_mask   = NUM_ELEM'($urandom);
        req_scalar = REC_W'($urandom);
        req_vec    = rand_vec();
    endtask

    // One full transaction: beat sequence, latency, exception OR, result capture and DONE hold.
    // exc_cycle > 0 drives only NV in that cycle (0 = random flags every cycle); drain_res < 0 = random result.
    task automatic run_req(input string name, input logic [1:0] op, input logic [2:0] rm, input logic [VL_W-1:0] vl,
                           input logic [NUM_ELEM-1:0] mask, input logic [REC_W-1:0] scalar,
                           input logic [NUM_ELEM*REC_W-1:0] vec, input int exc_cycle, input int drain_res,
                           input int hold);
        int             vl_eff;
        int             bidx[$];
        bit             ben[$];
        bit             bsel[$];
        int             nb;
        logic [1:0]     exp_op;
        logic [FN_W-1:0] exp_res;
        logic [FN_W-1:0] res_d;
        logic [4:0]     exp_exc;
        logic [4:0]     exc_d;
        logic [REC_W-1:0] exp_c;

        vl_eff = (int'(vl) > NUM_ELEM) ? NUM_ELEM : int'(vl);
        exp_op = (op == 2'd1) ? 2'd0 : op;
        if (vl_eff == 0) begin
            bidx.push_back(0); ben.push_back(1'b0); bsel.push_back(1'b0);
        end else begin
            for (int k = 0; k < vl_eff; k++) begin
`ifdef TT_VFP_RED_SEQ_SKIP_EN
                if (k != 0 && !mask[k]) continue;
`endif
                bidx.push_back(k); ben.push_back(mask[k]); bsel.push_back(k != 0);
            end
        end
        nb      = bidx.size();
        exp_exc = '0;
        exp_res = '0;

        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL %s idle_ready: got %b expected 1", name, req_ready);
        end
        req_op = op; req_rm = rm; req_vl = vl; req_mask = mask; req_scalar = scalar; req_vec = vec;
        req_valid = 1'b1;
        @(posedge clk);

        for (int t = 1; t <= nb + 1; t++) begin
            @(negedge clk);
            if (t == 1) begin
                req_valid = 1'b0;
                scramble_req();
            end
            if (t <= nb) begin
                exp_c = vec[bidx[t-1]*REC_W +: REC_W];
                n_checks++;
                if ({red_valid, red_en, red_sel, res_valid, req_ready} !== {1'b1, ben[t-1], bsel[t-1], 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL %s beat%0d_ctl: got v/en/sel/rv/rr=%b%b%b%b%b expected %b%b%b00",
                             name, t - 1, red_valid, red_en, red_sel, res_valid, req_ready, 1'b1, ben[t-1], bsel[t-1]);
                end
                n_checks++;
                if (red_c !== exp_c) begin
                    n_fail++; $display("[TB] FAIL %s beat%0d_c: got %h expected %h", name, t - 1, red_c, exp_c);
                end
                n_checks++;
                if ({red_op, red_rm, red_a} !== {exp_op, rm, scalar}) begin
                    n_fail++;
                    $display("[TB] FAIL %s beat%0d_oprma: got %h/%h/%h expected %h/%h/%h",
                             name, t - 1, red_op, red_rm, red_a, exp_op, rm, scalar);
                end
            end else begin
                n_checks++;
                if ({red_valid, res_valid} !== 2'b00) begin
                    n_fail++; $display("[TB] FAIL %s drain: got red_valid/res_valid=%b%b expected 00", name, red_valid, res_valid);
                end
            end
            res_d = (drain_res >= 0) ? FN_W'(drain_res) : FN_W'($urandom);
            exc_d = (exc_cycle > 0) ? ((t == exc_cycle) ? 5'h10 : 5'h00) : 5'($urandom);
            red_res = res_d;
            red_exc = exc_d;
            if (t >= 2) exp_exc |= exc_d;
            if (t == nb + 1) exp_res = res_d;
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            n_checks++;
            if ({res_valid, req_ready, red_valid} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL %s done%0d_ctl: got res_valid/req_ready/red_valid=%b%b%b expected 100",
                         name, h, res_valid, req_ready, red_valid);
            end
            n_checks++;
            if ({res, exc} !== {exp_res, exp_exc}) begin
                n_fail++;
                $display("[TB] FAIL %s done%0d_res: got %h/%h expected %h/%h", name, h, res, exc, exp_res, exp_exc);
            end
            red_res = FN_W'($urandom);
            red_exc = 5'($urandom);
            if (h < hold) begin
                req_valid = 1'b1;
                scramble_req();
            end else begin
                req_valid = 1'b0;
                res_ready = 1'b1;
            end
        end

        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, req_ready, red_valid, red_op, red_rm, red_a} !== {3'b010, 2'b0, 3'b0, {REC_W{1'b0}}}) begin
            n_fail++;
            $display("[TB] FAIL %s handshake: got res_valid/req_ready/red_valid=%b%b%b op=%h rm=%h a=%h expected 010 zeros",
                     name, res_valid, req_ready, red_valid, red_op, red_rm, red_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        scramble_req();
        red_res = '0; red_exc = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({red_valid, red_en, red_sel, red_op, red_rm, red_a, red_c, res_valid, res, exc} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got v/en/sel=%b%b%b a=%h c=%h res_valid=%b res=%h exc=%h expected all zero",
                     red_valid, red_en, red_sel, red_a, red_c, res_valid, res, exc);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_sum();
        run_req("sum_vl3", 2'd0, 3'd0, 4'd3, 8'hFF, 17'h07C00,
                pack4(17'h08000, 17'h08400, 17'h08600, 17'h1FFFF), 0, 16'h4680, 0);
    endtask

    task automatic test_vl_zero();
        run_req("vl_zero", 2'd3, 3'd1, 4'd0, 8'hFF, 17'h08000, rand_vec(), 0, 16'h3C00, 0);
    endtask

    task automatic test_max_skip();
        run_req("max_mask1101", 2'd3, 3'd0, 4'd4, 8'b0000_1101, 17'h18000,
                pack4(17'h08800, 17'h08C80, 17'h08400, 17'h08B00), 0, 16'h4700, 1);
    endtask

    task automatic test_sticky_nv();
        run_req("min_snan", 2'd2, 3'd0, 4'd3, 8'hFF, 17'h08000,
                pack4(17'h08000, 17'h0E001, 17'h08000, 17'h08000), 3, 16'h3C00, 0);
    endtask

    task automatic test_backpressure();
        run_req("hold10", 2'd1, 3'd4, 4'd5, 8'hA5, 17'h12345, rand_vec(), 0, -1, 10);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        req_op = 2'd0; req_rm = 3'd0; req_vl = 4'd8; req_mask = 8'hFF; req_scalar = 17'h08000; req_vec = rand_vec();
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({red_valid, red_en, red_sel, red_op, red_rm, red_a, red_c, res_valid, res, exc} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got v/en/sel=%b%b%b a=%h c=%h res_valid=%b expected all zero",
                     red_valid, red_en, red_sel, red_a, red_c, res_valid);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midreset_ready: got %b expected 1", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        run_req("after_reset", 2'd2, 3'd2, 4'd6, 8'h3C, 17'h00ABC, rand_vec(), 0, -1, 0);
    endtask

    task automatic test_back_to_back();
        run_req("b2b_a", 2'd0, 3'd0, 4'd2, 8'h01, 17'h00111, rand_vec(), 0, -1, 0);
        run_req("b2b_b", 2'd3, 3'd3, 4'd15, 8'h81, 17'h00222, rand_vec(), 0, -1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("rand%0d", i), 2'($urandom), 3'($urandom), VL_W'($urandom_range(0, 15)),
                    NUM_ELEM'($urandom), REC_W'($urandom), rand_vec(), 0, -1, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_sum();
        test_vl_zero();
        test_max_skip();
        test_sticky_nv();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
